// File: rtl/bp_pkg.sv
// Shared encodings for the branch predictor: 2-bit counter states and default history width.
// BPT_BYPASS_EN (optional define) is consumed by branch_pred_table, not here.
package bp_pkg;

   typedef logic [1:0] cnt_t;

   localparam cnt_t CNT_SNT = 2'b00;
   localparam cnt_t CNT_WNT = 2'b01;
   localparam cnt_t CNT_WT  = 2'b10;
   localparam cnt_t CNT_ST  = 2'b11;

   localparam int   BHR_WIDTH_DFLT = 4;
   localparam cnt_t CNT_RESET      = CNT_WNT;

endpackage

// File: rtl/branch_pred_table_bhr_reg.sv
// Global branch history register: next state by priority reset > repair > shift > hold.
// One-cycle update; current history is exposed straight from the flop.
module bhr_reg #(
   parameter int W = 4
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         shift_en,
   input  logic         shift_bit,
   input  logic         repair_en,
   input  logic [W-2:0] repair_hist,
   input  logic         repair_bit,
   output logic [W-1:0] hist
);

   logic [W-1:0] hist_d;
   logic [W-1:0] hist_q;

   always_comb begin
      hist_d = hist_q;
      // A repair means the same-cycle fetch is on the wrong path, so it wins over the shift.
      if (repair_en) begin
         hist_d = {repair_hist, repair_bit};
      end else if (shift_en) begin
         hist_d = {hist_q[W-2:0], shift_bit};
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         hist_q <= '0;
      end else begin
         hist_q <= hist_d;
      end
   end

   assign hist = hist_q;

endmodule

// File: rtl/branch_pred_table.sv
// Global-history branch predictor: BHR plus 2**BHR_WIDTH-entry table of 2-bit counters; prediction is 0-cycle combinational.
// Define BPT_BYPASS_EN to forward a same-cycle table write into the prediction; no backpressure, writes land at the next edge.
module branch_pred_table
   import bp_pkg::*;
#(
   parameter int         BHR_WIDTH = BHR_WIDTH_DFLT,
   parameter logic [1:0] CNT_RESET = CNT_WNT
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 fetch_valid,
   output logic                 pred_taken,
   output logic [BHR_WIDTH-1:0] pred_index,
   input  logic                 resolve_valid,
   input  logic [BHR_WIDTH-1:0] resolve_index,
   input  logic                 resolve_pred,
   input  logic                 resolve_taken,
   output logic [1:0]           cnt_to_update,
   input  logic [1:0]           cnt_from_update,
   output logic                 mispredict
);

   localparam int DEPTH = 2 ** BHR_WIDTH;

   logic [1:0]           bpt_q [DEPTH];
   logic [1:0]           bpt_d [DEPTH];
   logic [BHR_WIDTH-1:0] bhr;

   assign mispredict    = resolve_valid & (resolve_pred != resolve_taken);
   assign pred_index    = bhr;
   assign cnt_to_update = bpt_q[resolve_index];

`ifdef BPT_BYPASS_EN
   always_comb begin
      pred_taken = bpt_q[bhr][1];
      if (resolve_valid && (resolve_index == bhr)) begin
         pred_taken = cnt_from_update[1];
      end
   end
`else
   assign pred_taken = bpt_q[bhr][1];
`endif

   always_comb begin
      bpt_d = bpt_q;
      if (resolve_valid) begin
         bpt_d[resolve_index] = cnt_from_update;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            bpt_q[i] <= CNT_RESET;
         end
      end else begin
         bpt_q <= bpt_d;
      end
   end

   bhr_reg #(
      .W (BHR_WIDTH)
   ) u_bhr_reg (
      .clock       (clock),
      .reset       (reset),
      .shift_en    (fetch_valid),
      .shift_bit   (pred_taken),
      .repair_en   (mispredict),
      .repair_hist (resolve_index[BHR_WIDTH-2:0]),
      .repair_bit  (resolve_taken),
      .hist        (bhr)
   );

endmodule

// File: tb/tb_branch_pred_table.sv
// Directed bench for branch_pred_table: reset, shift, table write, repair, collision, reset mid-operation.
// Collision expectation follows BPT_BYPASS_EN when the bench is built with it.
module tb_branch_pred_table;

   logic       clock = 1'b0;
   logic       reset;
   logic       fetch_valid;
   logic       pred_taken;
   logic [3:0] pred_index;
   logic       resolve_valid;
   logic [3:0] resolve_index;
   logic       resolve_pred;
   logic       resolve_taken;
   logic [1:0] cnt_to_update;
   logic [1:0] cnt_from_update;
   logic       mispredict;

   int n_total = 0;
   int n_pass  = 0;

   always #5 clock = ~clock;

   branch_pred_table dut (
      .clock           (clock),
      .reset           (reset),
      .fetch_valid     (fetch_valid),
      .pred_taken      (pred_taken),
      .pred_index      (pred_index),
      .resolve_valid   (resolve_valid),
      .resolve_index   (resolve_index),
      .resolve_pred    (resolve_pred),
      .resolve_taken   (resolve_taken),
      .cnt_to_update   (cnt_to_update),
      .cnt_from_update (cnt_from_update),
      .mispredict      (mispredict)
   );

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic check_cnt(input string tag, input logic [3:0] idx, input logic [1:0] exp);
      resolve_index = idx;
      #1;
      check(tag, {2'b00, cnt_to_update}, {2'b00, exp});
   endtask

   initial begin
      reset = 1'b1; fetch_valid = 1'b0; resolve_valid = 1'b0; resolve_index = 4'd0;
      resolve_pred = 1'b0; resolve_taken = 1'b0; cnt_from_update = 2'b00;
      step();
      reset = 1'b0;
      #1;
      check("rst_index", pred_index, 4'd0);
      check("rst_taken", {3'b000, pred_taken}, 4'd0);
      check("rst_mispredict", {3'b000, mispredict}, 4'd0);
      for (int i = 0; i < 16; i++) begin
         check_cnt($sformatf("rst_cnt_%0d", i), 4'(i), 2'b01);
      end

      // Three fetches predicting not-taken keep the history at zero.
      resolve_index = 4'd0;
      fetch_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check($sformatf("shift0_%0d", i), pred_index, 4'd0);
      end
      fetch_valid = 1'b0;

      resolve_valid = 1'b1; resolve_index = 4'd0; cnt_from_update = 2'b10;
      step();
      resolve_valid = 1'b0;
      check_cnt("wr0_cnt", 4'd0, 2'b10);
      check("wr0_taken", {3'b000, pred_taken}, 4'd1);
      fetch_valid = 1'b1;
      step();
      fetch_valid = 1'b0;
      #1;
      check("shift1_index", pred_index, 4'b0001);

      resolve_valid = 1'b1; resolve_index = 4'd5; cnt_from_update = 2'b11;
      step();
      resolve_valid = 1'b0;
      check_cnt("wr5_cnt", 4'd5, 2'b11);
      check_cnt("wr5_nb4", 4'd4, 2'b01);
      check_cnt("wr5_nb6", 4'd6, 2'b01);

      // Repair into history 0110 first, writing back the unchanged counter.
      resolve_valid = 1'b1; resolve_index = 4'b1011; resolve_pred = 1'b1; resolve_taken = 1'b0;
      cnt_from_update = 2'b01;
      #1;
      check("setup_mispredict", {3'b000, mispredict}, 4'd1);
      step();
      check("setup_bhr", pred_index, 4'b0110);
      resolve_pred = 1'b0; resolve_taken = 1'b1; fetch_valid = 1'b1;
      #1;
      check("rep_mispredict", {3'b000, mispredict}, 4'd1);
      step();
      fetch_valid = 1'b0;
      #1;
      check("rep_bhr", pred_index, 4'b0111);

      // Correct prediction with no fetch: history holds.
      resolve_pred = 1'b1; resolve_taken = 1'b1;
      #1;
      check("ok_mispredict", {3'b000, mispredict}, 4'd0);
      step();
      check("ok_hold", pred_index, 4'b0111);

      // Repair to history 0011 via index 0001, taken.
      resolve_index = 4'b0001; resolve_pred = 1'b0; resolve_taken = 1'b1; cnt_from_update = 2'b01;
      step();
      check("col_bhr", pred_index, 4'd3);
      resolve_valid = 1'b0;
      #1;
      check("col_pre", {3'b000, pred_taken}, 4'd0);
      resolve_valid = 1'b1; resolve_index = 4'd3; resolve_pred = 1'b0; resolve_taken = 1'b0;
      cnt_from_update = 2'b10;
      #1;
`ifdef BPT_BYPASS_EN
      check("col_same", {3'b000, pred_taken}, 4'd1);
`else
      check("col_same", {3'b000, pred_taken}, 4'd0);
`endif
      step();
      resolve_valid = 1'b0;
      #1;
      check("col_next", {3'b000, pred_taken}, 4'd1);
      check_cnt("col_cnt", 4'd3, 2'b10);

      reset = 1'b1; resolve_valid = 1'b1; resolve_index = 4'd2; cnt_from_update = 2'b11;
      fetch_valid = 1'b1;
      step();
      reset = 1'b0; resolve_valid = 1'b0; fetch_valid = 1'b0;
      #1;
      check("rstmid_bhr", pred_index, 4'd0);
      check_cnt("rstmid_cnt2", 4'd2, 2'b01);
      check_cnt("rstmid_cnt3", 4'd3, 2'b01);
      check_cnt("rstmid_cnt0", 4'd0, 2'b01);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
